// File: rtl/vram_write_scheduler.sv
// Single write port arbiter for the 32x32 video memory: CPU cell writes always win,
// and a rectangle-fill engine uses every cycle the CPU leaves free.
module vram_write_scheduler #(
    parameter int COLOR_W = 3,
    parameter int COORD_W = 5
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   iCpuWrite,
    input  logic [2*COORD_W-1:0]   iCpuAddr,
    input  logic [COLOR_W-1:0]     iCpuColor,
    input  logic                   iFillStart,
    input  logic [COORD_W-1:0]     iFillX0,
    input  logic [COORD_W-1:0]     iFillY0,
    input  logic [COORD_W-1:0]     iFillX1,
    input  logic [COORD_W-1:0]     iFillY1,
    input  logic [COLOR_W-1:0]     iFillColor,
    input  logic                   iFillAbort,
    output logic                   oVmWrite,
    output logic [2*COORD_W-1:0]   oVmAddr,
    output logic [COLOR_W-1:0]     oVmData,
    output logic                   oFillBusy,
    output logic                   oFillDone,
    output logic                   oFillReject
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [COORD_W-1:0]     cx_q, cx_d, cy_q, cy_d;
    logic [COORD_W-1:0]     x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
    logic [COLOR_W-1:0]     color_q, color_d;
    logic                   vm_write_q, vm_write_d;
    logic [2*COORD_W-1:0]   vm_addr_q, vm_addr_d;
    logic [COLOR_W-1:0]     vm_data_q, vm_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   reject_q, reject_d;

    logic start_ok, rect_ok, fill_issue, fill_last;

    // A start is only considered while fully idle, including the cycle the done pulse is visible.
    assign start_ok   = (state_q == S_IDLE) && !busy_q && iFillStart && !iFillAbort;
    assign rect_ok    = (iFillX0 <= iFillX1) && (iFillY0 <= iFillY1);
    assign fill_issue = (state_q == S_FILL) && !iCpuWrite && !iFillAbort;
    assign fill_last  = (cx_q == x1_q) && (cy_q == y1_q);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            cx_q       <= '0;
            cy_q       <= '0;
            x0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            color_q    <= '0;
            vm_write_q <= 1'b0;
            vm_addr_q  <= '0;
            vm_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            color_q    <= color_d;
            vm_write_q <= vm_write_d;
            vm_addr_q  <= vm_addr_d;
            vm_data_q  <= vm_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            reject_q   <= reject_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok && rect_ok) state_d = S_FILL;
            end
            S_FILL: begin
                if (iFillAbort)                   state_d = S_IDLE;
                else if (fill_issue && fill_last) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Cursor walks row-major; equality compares keep X1/Y1 at the top coordinate from wrapping.
    always_comb begin
        cx_d    = cx_q;
        cy_d    = cy_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        color_d = color_q;
        if (start_ok && rect_ok) begin
            cx_d    = iFillX0;
            cy_d    = iFillY0;
            x0_d    = iFillX0;
            x1_d    = iFillX1;
            y1_d    = iFillY1;
            color_d = iFillColor;
        end else if (fill_issue) begin
            if (cx_q != x1_q) begin
                cx_d = cx_q + 1'b1;
            end else if (cy_q != y1_q) begin
                cx_d = x0_q;
                cy_d = cy_q + 1'b1;
            end
        end
    end

    always_comb begin
        vm_write_d = iCpuWrite || fill_issue;
        vm_addr_d  = iCpuWrite ? iCpuAddr  : {cy_q, cx_q};
        vm_data_d  = iCpuWrite ? iCpuColor : color_q;
        done_d     = (state_q == S_DONE) && !iFillAbort;
        reject_d   = start_ok && !rect_ok;
        // Busy stays up through the visible done pulse so both fall together.
        busy_d     = (state_d != S_IDLE) || done_d;
    end

    assign oVmWrite    = vm_write_q;
    assign oVmAddr     = vm_addr_q;
    assign oVmData     = vm_data_q;
    assign oFillBusy   = busy_q;
    assign oFillDone   = done_q;
    assign oFillReject = reject_q;

endmodule

// File: doc/vram_write_scheduler.md
# vram_write_scheduler

Owns the single write port of the 32x32-cell, 3-bit video memory and shares it between two requesters: single-cell writes from the CPU `WVM` instruction and a hardware rectangle-fill engine. The fill engine lets software clear or paint regions without a per-cell instruction loop. CPU writes have strict priority, and the fill engine stalls on any cycle the CPU writes. Every write the memory sees comes from this block's registered outputs.

## Interface
- `COLOR_W`, default 3: colour width in bits.
- `COORD_W`, default 5: cell coordinate width; the address is `2*COORD_W` bits wide, packed as `{y, x}` (row high, column low).
- `Clock`  in  1  system clock; all logic on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `iCpuWrite`  in  1  one-cycle CPU write request (the `WVM` decode).
- `iCpuAddr`  in  2*COORD_W  CPU target cell `{y, x}`.
- `iCpuColor`  in  COLOR_W  CPU colour.
- `iFillStart`  in  1  one-cycle fill command strobe.
- `iFillX0`, `iFillY0`, `iFillX1`, `iFillY1`  in  COORD_W each  inclusive rectangle corners.
- `iFillColor`  in  COLOR_W  fill colour.
- `iFillAbort`  in  1  one-cycle abort of the running fill.
- `oVmWrite`  out  1  memory write enable (registered).
- `oVmAddr`  out  2*COORD_W  memory write address (registered).
- `oVmData`  out  COLOR_W  memory write data (registered).
- `oFillBusy`  out  1  high while the fill engine is in FILL or DONE.
- `oFillDone`  out  1  one-cycle pulse when a fill completes.
- `oFillReject`  out  1  one-cycle pulse when a command is rejected.

## Operation
- **Reset values:** all outputs 0; state IDLE; internal coordinate and colour registers 0.
- **Arbitration:** each cycle, at most one write is issued. `iCpuWrite`=1 always wins. The fill engine issues only when it is in FILL and `iCpuWrite`=0. A CPU write is never dropped or delayed.
- **IDLE:**
  - On `iFillStart`=1 with `iFillX0`<=`iFillX1` and `iFillY0`<=`iFillY1`: latch all fill inputs, set the cursor to (X0,Y0), go to FILL.
  - On `iFillStart`=1 with a degenerate rectangle (`iFillX1`<`iFillX0` or `iFillY1`<`iFillY0`): pulse `oFillReject` next cycle and stay in IDLE.
  - If `iFillStart` and `iFillAbort` arrive together: abort wins and the start is ignored (no reject pulse).
- **FILL:**
  - Stall cycle (`iCpuWrite`=1): cursor holds.
  - Issue cycle: write colour at cursor `{cy, cx}`, then advance the cursor:
    - `cx`!=X1: increment `cx`.
    - `cx`==X1 and `cy`!=Y1: set `cx`=X0, increment `cy`.
    - `cx`==X1 and `cy`==Y1: go to DONE.
  - End detection uses equality compares, so X1=Y1=31 never overflows.
- **DONE:** pulse `oFillDone` for one cycle, then return to IDLE.
- **Abort:** `iFillAbort` in FILL or DONE goes to IDLE on the next edge. No further fill writes are issued and no done pulse is produced. Abort in IDLE is a no-op.
- **Busy start:** `iFillStart` while `oFillBusy`=1 is ignored silently, with no reject pulse and no change to the running fill.
- **Write count:** a fill of a W×H rectangle issues exactly W*H writes, in row-major order from (X0,Y0) to (X1,Y1).

## Timing
- CPU write presented in cycle N appears on `oVm*` in cycle N+1, with `oVmWrite`=1 for exactly one cycle.
- Fill start accepted in cycle N:
  - `oFillBusy`=1 from N+1.
  - First fill write appears on `oVm*` at N+2 if there is no CPU write at N+1.
- With no stalls, the last fill write appears at N+1+W*H.
- `oFillDone` pulses at N+2+W*H, and `oFillBusy` drops in the same cycle `oFillDone` falls.
- Each CPU stall cycle delays the remaining fill schedule by exactly one cycle.
- `oFillReject` pulses in cycle N+1 for a degenerate start in cycle N.
- Asserting `Reset` asynchronously in any state clears `oVmWrite` immediately. No partial write is emitted after reset release.

## Test plan
- **CPU write only:** `iCpuWrite`=1, addr=0x3A5, colour=5 at cycle N -> `oVmWrite`=1, `oVmAddr`=0x3A5, `oVmData`=5 at N+1, and 0 at N+2.
- **Fill 2x2:** X0=3, Y0=4, X1=4, Y1=5, colour=2 -> writes to 0x083, 0x084, 0x0A3, 0x0A4 on consecutive cycles; `oFillDone` one cycle after the last write; busy covers the whole span.
- **CPU stall mid-fill:** during the 2x2 fill, `iCpuWrite` (addr=0x000, colour=7) on the second issue cycle -> the CPU write appears in that slot and the fill resumes at 0x084; total 5 writes; done is one cycle later than unstalled.
- **Degenerate and busy starts:**
  - X0=6, X1=2 -> `oFillReject` pulse and no writes.
  - A start while busy -> ignored; the original rectangle completes unchanged.
- **Full screen and abort:**
  - 0..31 × 0..31 fill -> 1024 writes, last address 0x3FF, no wrap.
  - Abort after 10 writes -> no further writes and no done pulse.
- **Reset mid-fill:** drive `Reset`=0 during FILL -> all outputs 0 immediately; after release, state is IDLE and no writes occur until a new command.
